// File: rtl/tick_sched_if.sv
// tick_sched_if: configuration request channel into tick_sched.
// The master drives a request and holds it until it sees cfg_ready; the slave accepts it on that edge.
interface tick_sched_if #(parameter int CNT_W = 10);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [1:0]       cfg_ch;
    logic [CNT_W-1:0] cfg_load;
    logic             cfg_periodic;
    logic             cfg_stop;
    modport master (output cfg_valid, cfg_ch, cfg_load, cfg_periodic, cfg_stop, input cfg_ready);
    modport slave  (input cfg_valid, cfg_ch, cfg_load, cfg_periodic, cfg_stop, output cfg_ready);
endinterface

// File: rtl/tick_sched.sv
// tick_sched: four timer channels served by one shared decrementer, one slot per channel after each 1 ms tick.
// Define TICK_SCHED_OVERRUN_EN to flag, with a sticky bit, ticks that arrive while a scan is in progress.
module tick_sched #(
    parameter int CNT_W = 10,
    parameter int NCH   = 4
) (
    input  logic           sclk,
    input  logic           rst_n,
    input  logic           tick_1ms,
    tick_sched_if.slave    cfg,
    output logic [NCH-1:0] active,
    output logic [NCH-1:0] expire,
    output logic           busy,
    output logic           overrun
);
    typedef enum logic {IDLE, SCAN} state_t;
    state_t           state_q;
    logic [1:0]       slot_q;
    logic [CNT_W-1:0] cnt_q  [NCH];
    logic [CNT_W-1:0] load_q [NCH];
    logic [NCH-1:0]   per_q;
    logic [NCH-1:0]   active_q;
    logic [NCH-1:0]   expire_q;
    logic [CNT_W-1:0] load_d;
    logic             hit_d;
    // A zero load behaves as one so the channel can never sit active with nothing to count.
    assign load_d = (cfg.cfg_load == '0) ? CNT_W'(1) : cfg.cfg_load;
    assign hit_d = cnt_q[slot_q] <= CNT_W'(1);
    assign cfg.cfg_ready = rst_n && state_q == IDLE && !tick_1ms;
    assign active = active_q;
    assign expire = expire_q;
    assign busy = state_q == SCAN;
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            slot_q <= '0;
            per_q <= '0;
            active_q <= '0;
            expire_q <= '0;
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= '0;
                load_q[i] <= '0;
            end
        end else begin
            expire_q <= '0;
            if (state_q == IDLE) begin
                if (tick_1ms) begin
                    state_q <= SCAN;
                    slot_q <= '0;
                end else if (cfg.cfg_valid && cfg.cfg_stop) begin
                    active_q[cfg.cfg_ch] <= 1'b0;
                    cnt_q[cfg.cfg_ch] <= '0;
                end else if (cfg.cfg_valid) begin
                    load_q[cfg.cfg_ch] <= load_d;
                    cnt_q[cfg.cfg_ch] <= load_d;
                    per_q[cfg.cfg_ch] <= cfg.cfg_periodic;
                    active_q[cfg.cfg_ch] <= 1'b1;
                end
            end else begin
                slot_q <= slot_q + 2'd1;
                if (slot_q == 2'(NCH - 1))
                    state_q <= IDLE;
                if (active_q[slot_q] && hit_d) begin
                    expire_q[slot_q] <= 1'b1;
                    cnt_q[slot_q] <= per_q[slot_q] ? load_q[slot_q] : '0;
                    active_q[slot_q] <= per_q[slot_q];
                end else if (active_q[slot_q]) begin
                    cnt_q[slot_q] <= cnt_q[slot_q] - CNT_W'(1);
                end
            end
        end
    end
`ifdef TICK_SCHED_OVERRUN_EN
    logic overrun_q;
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n)
            overrun_q <= 1'b0;
        else if (tick_1ms && state_q == SCAN)
            overrun_q <= 1'b1;
    end
    assign overrun = overrun_q;
`else
    assign overrun = 1'b0;
`endif
endmodule

// File: tb/tb_tick_sched.sv
// tb_tick_sched: directed scenarios for tick_sched; expected expire pulses are queued as (channel, cycle)
// pairs when a tick is issued and a monitor pops and compares them whenever expire is non-zero.
module tb_tick_sched;
    logic       sclk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick_1ms = 1'b0;
    logic [3:0] active;
    logic [3:0] expire;
    logic       busy;
    logic       overrun;
    int         cyc = 0;
    int         n_vec = 0;
    int         n_bad = 0;
    typedef struct {int ch; int cyc;} exp_t;
    exp_t       exp_q[$];
    exp_t       e_m;

    tick_sched_if #(.CNT_W(10)) cfg_if ();

    tick_sched #(.CNT_W(10), .NCH(4)) dut (
        .sclk(sclk), .rst_n(rst_n), .tick_1ms(tick_1ms), .cfg(cfg_if),
        .active(active), .expire(expire), .busy(busy), .overrun(overrun)
    );

    always #10 sclk = ~sclk;
    always @(posedge sclk) cyc <= cyc + 1;

    always @(negedge sclk) begin
        if (rst_n) begin
            for (int k = 0; k < 4; k++) begin
                if (expire[k]) begin
                    n_vec++;
                    if (exp_q.size() == 0) begin
                        n_bad++;
                        $display("FAIL expire_unexpected: ch%0d pulsed at cycle %0d, none expected", k, cyc);
                    end else begin
                        e_m = exp_q.pop_front();
                        if (e_m.ch != k || e_m.cyc != cyc) begin
                            n_bad++;
                            $display("FAIL expire_match: got ch%0d at cycle %0d, expected ch%0d at cycle %0d", k, cyc, e_m.ch, e_m.cyc);
                        end
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge sclk);
        #1 rst_n = 1'b0;
        exp_q.delete();
        @(negedge sclk);
        check("rst_active", 32'(active), 0);
        check("rst_expire", 32'(expire), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_overrun", 32'(overrun), 0);
        check("rst_cfg_ready", 32'(cfg_if.cfg_ready), 0);
        repeat (2) @(posedge sclk);
        #1 rst_n = 1'b1;
    endtask

    // Expire on channel k lands two cycles after the drive cycle plus k slot cycles.
    task automatic do_tick(input logic [3:0] mask);
        @(posedge sclk);
        #1 tick_1ms = 1'b1;
        for (int k = 0; k < 4; k++)
            if (mask[k]) exp_q.push_back('{k, cyc + 2 + k});
        @(posedge sclk);
        #1 tick_1ms = 1'b0;
        check("busy_in_scan", 32'(busy), 1);
        repeat (6) @(posedge sclk);
    endtask

    task automatic do_cfg(input logic [1:0] ch, input logic [9:0] load, input logic per, input logic stop);
        int w;
        w = 0;
        @(posedge sclk);
        #1;
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_ch = ch;
        cfg_if.cfg_load = load;
        cfg_if.cfg_periodic = per;
        cfg_if.cfg_stop = stop;
        @(negedge sclk);
        while (!cfg_if.cfg_ready && w < 20) begin
            @(negedge sclk);
            w++;
        end
        check("cfg_accept", 32'(cfg_if.cfg_ready), 1);
        @(posedge sclk);
        #1 cfg_if.cfg_valid = 1'b0;
    endtask

    initial begin
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_ch = '0;
        cfg_if.cfg_load = '0;
        cfg_if.cfg_periodic = 1'b0;
        cfg_if.cfg_stop = 1'b0;
        do_reset();
        @(negedge sclk);
        check("ready_idle", 32'(cfg_if.cfg_ready), 1);

        // one-shot ch0 load 3
        do_cfg(2'd0, 10'd3, 1'b0, 1'b0);
        check("os_active", 32'(active), 32'h1);
        do_tick(4'b0000);
        do_tick(4'b0000);
        do_tick(4'b0001);
        check("os_done", 32'(active), 0);
        check("idle_busy", 32'(busy), 0);

        // periodic ch2 load 2
        do_reset();
        do_cfg(2'd2, 10'd2, 1'b1, 1'b0);
        for (int t = 1; t <= 6; t++) do_tick((t % 2 == 0) ? 4'b0100 : 4'b0000);
        check("per_active", 32'(active), 32'h4);

        // stop, then restart without expire
        do_reset();
        do_cfg(2'd1, 10'd5, 1'b0, 1'b0);
        do_tick(4'b0000);
        do_tick(4'b0000);
        do_cfg(2'd1, 10'd0, 1'b0, 1'b1);
        check("stop_active", 32'(active), 0);
        for (int t = 0; t < 4; t++) do_tick(4'b0000);
        do_cfg(2'd1, 10'd5, 1'b0, 1'b0);
        do_tick(4'b0000);
        do_tick(4'b0000);
        do_cfg(2'd1, 10'd2, 1'b0, 1'b0);
        check("restart_active", 32'(active), 32'h2);
        do_tick(4'b0000);
        do_tick(4'b0010);
        check("restart_done", 32'(active), 0);

        // all channels load 1 (ch3 load 0 acts as 1)
        do_reset();
        do_cfg(2'd0, 10'd1, 1'b0, 1'b0);
        do_cfg(2'd1, 10'd1, 1'b0, 1'b0);
        do_cfg(2'd2, 10'd1, 1'b1, 1'b0);
        do_cfg(2'd3, 10'd0, 1'b0, 1'b0);
        check("all_active", 32'(active), 32'hf);
        do_tick(4'b1111);
        check("all_after", 32'(active), 32'h4);

        // tick collides with cfg_valid: request waits out the scan
        do_reset();
        @(posedge sclk);
        #1;
        tick_1ms = 1'b1;
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_ch = 2'd3;
        cfg_if.cfg_load = 10'd2;
        cfg_if.cfg_periodic = 1'b0;
        cfg_if.cfg_stop = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge sclk);
            check("ready_blocked", 32'(cfg_if.cfg_ready), 0);
            @(posedge sclk);
            #1 tick_1ms = 1'b0;
        end
        @(negedge sclk);
        check("ready_after_scan", 32'(cfg_if.cfg_ready), 1);
        @(posedge sclk);
        #1 cfg_if.cfg_valid = 1'b0;
        @(negedge sclk);
        check("late_accept", 32'(active), 32'h8);

        // second tick two cycles after the first is dropped
        do_reset();
        do_cfg(2'd0, 10'd2, 1'b0, 1'b0);
        @(posedge sclk);
        #1 tick_1ms = 1'b1;
        @(posedge sclk);
        #1 tick_1ms = 1'b0;
        @(posedge sclk);
        #1 tick_1ms = 1'b1;
        @(posedge sclk);
        #1 tick_1ms = 1'b0;
        repeat (6) @(posedge sclk);
        @(negedge sclk);
`ifdef TICK_SCHED_OVERRUN_EN
        check("overrun_set", 32'(overrun), 1);
`else
        check("overrun_tied", 32'(overrun), 0);
`endif
        check("overrun_still_active", 32'(active), 32'h1);
        do_tick(4'b0001);
        do_reset();
        @(negedge sclk);
        check("overrun_cleared", 32'(overrun), 0);

        // reset in the middle of a scan, then a cold start
        do_cfg(2'd0, 10'd1, 1'b0, 1'b0);
        @(posedge sclk);
        #1 tick_1ms = 1'b1;
        @(posedge sclk);
        #1 tick_1ms = 1'b0;
        do_reset();
        repeat (8) @(posedge sclk);
        @(negedge sclk);
        check("midscan_active", 32'(active), 0);
        do_cfg(2'd0, 10'd2, 1'b0, 1'b0);
        do_tick(4'b0000);
        do_tick(4'b0001);

        repeat (10) @(posedge sclk);
        check("queue_drained", 32'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
